// File: rtl/lms_fifo_reader.sv
// Read-side drain engine: waits for a full frame in the async FIFO, bursts it out through the
// 1-cycle-latency read port, and streams it downstream via a 2-entry skid buffer.
module lms_fifo_reader #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH_WIDTH = 10,
  parameter int unsigned FRAME_LEN   = 32
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic [DEPTH_WIDTH:0]  fifo_rd_water_level,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [15:0]           frame_cnt,
  output logic                  underrun
);

  localparam int unsigned CntW = DEPTH_WIDTH + 1;
  localparam logic [CntW-1:0] FrameLen = CntW'(FRAME_LEN);
  localparam logic [CntW-1:0] LastIdx  = CntW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

  state_e                state_q;
  logic [CntW-1:0]       issued_q;
  logic [CntW-1:0]       out_cnt_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            buf_cnt_q;
  logic [1:0]            buf_cnt_d;
  logic [15:0]           frame_cnt_q;
  logic                  underrun_q;

  logic pop;
  logic push;
  logic room;
  logic start;
  logic frame_done;
  logic issue_left;

  assign push       = inflight_q;
  assign m_valid    = (buf_cnt_q != 2'd0);
  assign pop        = m_valid && m_ready;
  assign m_data     = buf_q[rd_ptr_q];
  assign m_last     = m_valid && (out_cnt_q == LastIdx);
  assign busy       = (state_q != StIdle);
  assign frame_cnt  = frame_cnt_q;
  assign underrun   = underrun_q;
  assign issue_left = (issued_q < FrameLen);

  // Buffered plus in-flight samples, net of this cycle's pop, must leave room for one more.
  assign room = ({1'b0, buf_cnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  assign fifo_rd_en = (state_q == StBurst) && !fifo_rd_empty && issue_left && room;
  assign start      = (state_q == StIdle) && enable && !fifo_rd_empty &&
                      (fifo_rd_water_level >= FrameLen);
  assign frame_done = (state_q == StDrain) && pop && m_last;
  assign buf_cnt_d  = buf_cnt_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      state_q     <= StIdle;
      issued_q    <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      buf_cnt_q   <= 2'd0;
      frame_cnt_q <= 16'd0;
      underrun_q  <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      buf_cnt_q  <= buf_cnt_d;
      if (push) begin
        buf_q[wr_ptr_q] <= fifo_rd_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q  <= ~rd_ptr_q;
        out_cnt_q <= out_cnt_q + 1'b1;
      end
      if (fifo_rd_en) begin
        issued_q <= issued_q + 1'b1;
      end
      if ((state_q == StBurst) && issue_left && fifo_rd_empty) begin
        underrun_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StBurst;
            issued_q  <= '0;
            out_cnt_q <= '0;
          end
        end
        StBurst: begin
          if (fifo_rd_en && (issued_q + 1'b1 == FrameLen)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (frame_done) begin
            state_q     <= StIdle;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lms_fifo_reader.sv
// Bench for lms_fifo_reader: behavioural 1-cycle-latency FIFO, scoreboard of expected samples,
// a table of threshold/enable vectors and hand-written multi-cycle corner sequences.
module tb_lms_fifo_reader;

  localparam int unsigned DW   = 16;
  localparam int unsigned DEPW = 10;
  localparam int unsigned FL   = 32;
  localparam int unsigned LW   = DEPW + 1;

  logic          rd_clk;
  logic          rd_rst_n;
  logic          enable;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_empty;
  logic [LW-1:0] fifo_rd_water_level;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic          underrun;

  lms_fifo_reader #(
    .DATA_WIDTH (DW),
    .DEPTH_WIDTH(DEPW),
    .FRAME_LEN  (FL)
  ) dut (
    .rd_clk             (rd_clk),
    .rd_rst_n           (rd_rst_n),
    .enable             (enable),
    .fifo_rd_en         (fifo_rd_en),
    .fifo_rd_data       (fifo_rd_data),
    .fifo_rd_empty      (fifo_rd_empty),
    .fifo_rd_water_level(fifo_rd_water_level),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .m_data             (m_data),
    .m_last             (m_last),
    .busy               (busy),
    .frame_cnt          (frame_cnt),
    .underrun           (underrun)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  typedef struct {
    logic en;
    int   preload;
    int   exp_reads;
    int   exp_frames;
  } vec_t;

  int            n_tests;
  int            n_fail;
  int            cyc;
  int            rd_cnt;
  int            pop_cnt;
  int            first_rd;
  int            first_vld;
  int            last_cyc;
  int            load_idx;
  int            max_buf;
  int            rdy_pat;
  int            t0;
  logic          force_empty;
  logic [DW-1:0] q[$];
  logic [DW-1:0] pend;
  logic [DW-1:0] salt;
  exp_t          sb[$];
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  vec_t          tv[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive the FIFO model and inputs at negedge, then sample and score.
  task automatic step();
    exp_t e;
    @(negedge rd_clk);
    fifo_rd_data        = pend;
    fifo_rd_empty       = force_empty || (q.size() == 0);
    fifo_rd_water_level = LW'(q.size());
    m_ready             = (rdy_pat == 0) || (cyc % 3 == 0);
    #1;
    cyc++;
    if (fifo_rd_en === 1'b1) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      chk("rd_en_while_empty", 32'(fifo_rd_empty), 32'd0);
      if (q.size() != 0) pend = q.pop_front();
    end
    if (rd_rst_n && (32'(dut.buf_cnt_q) > max_buf)) max_buf = 32'(dut.buf_cnt_q);
    if ((m_valid === 1'b1) && (first_vld < 0)) first_vld = cyc;
    if (prev_stall && rd_rst_n) begin
      chk("hold_data", 32'(m_data), 32'(prev_data));
      chk("hold_last", 32'(m_last), 32'(prev_last));
    end
    if ((m_valid === 1'b1) && m_ready) begin
      pop_cnt++;
      chk("sample_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("m_data", 32'(m_data), 32'(e.d));
        chk("m_last", 32'(m_last), 32'(e.l));
      end
      if (m_last === 1'b1) last_cyc = cyc;
    end
    prev_stall = rd_rst_n && (m_valid === 1'b1) && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
  endtask

  task automatic flush();
    q.delete();
    sb.delete();
    load_idx    = 0;
    rd_cnt      = 0;
    pop_cnt     = 0;
    first_rd    = -1;
    first_vld   = -1;
    last_cyc    = -1;
    max_buf     = 0;
    force_empty = 1'b0;
    prev_stall  = 1'b0;
  endtask

  task automatic do_reset();
    rd_rst_n = 1'b0;
    step();
    flush();
    step();
    step();
    rd_rst_n = 1'b1;
    step();
  endtask

  task automatic load(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d = salt ^ DW'(load_idx);
      e.l = ((load_idx % FL) == FL - 1);
      q.push_back(e.d);
      sb.push_back(e);
      load_idx++;
    end
  endtask

  task automatic wait_done(input int n_pops, input int budget);
    for (int i = 0; i < budget && !(pop_cnt >= n_pops && busy === 1'b0); i++) step();
    chk("frame_done_in_time", 32'(pop_cnt >= n_pops && busy === 1'b0), 32'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rdy_pat = 0;
    salt    = '0;
    pend    = '0;
    rd_rst_n = 1'b0;
    enable   = 1'b0;
    m_ready  = 1'b0;
    fifo_rd_data        = '0;
    fifo_rd_empty       = 1'b1;
    fifo_rd_water_level = '0;
    flush();

    // Reset and idle.
    repeat (3) step();
    chk("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    rd_rst_n = 1'b1;
    enable   = 1'b1;
    repeat (6) step();
    chk("idle_no_read", 32'(rd_cnt), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Threshold / enable vectors.
    tv[0] = '{en: 1'b1, preload: 31, exp_reads: 0,  exp_frames: 0};
    tv[1] = '{en: 1'b0, preload: 64, exp_reads: 0,  exp_frames: 0};
    tv[2] = '{en: 1'b1, preload: 32, exp_reads: 32, exp_frames: 1};
    tv[3] = '{en: 1'b1, preload: 64, exp_reads: 64, exp_frames: 2};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      salt   = DW'(i * 16'h1000);
      enable = tv[i].en;
      load(tv[i].preload);
      repeat (90) step();
      chk($sformatf("vec%0d_reads", i), 32'(rd_cnt), 32'(tv[i].exp_reads));
      chk($sformatf("vec%0d_pops", i), 32'(pop_cnt), 32'(tv[i].exp_reads));
      chk($sformatf("vec%0d_frames", i), 32'(frame_cnt), 32'(tv[i].exp_frames));
    end

    // Level 31 holds off, one more sample starts the frame.
    do_reset();
    salt   = 16'h5500;
    enable = 1'b1;
    load(31);
    repeat (10) step();
    chk("thr31_no_read", 32'(rd_cnt), 32'd0);
    load(1);
    wait_done(32, 100);
    chk("thr32_frames", 32'(frame_cnt), 32'd1);

    // Single frame at full rate with cycle-exact timing.
    do_reset();
    salt   = '0;
    enable = 1'b1;
    t0     = cyc + 1;
    load(32);
    wait_done(32, 100);
    chk("full_first_rd_en", 32'(first_rd), 32'(t0 + 1));
    chk("full_first_valid", 32'(first_vld), 32'(t0 + 3));
    chk("full_last_cycle", 32'(last_cyc), 32'(t0 + FL + 2));
    chk("full_rd_en_pulses", 32'(rd_cnt), 32'd32);
    chk("full_frame_cnt", 32'(frame_cnt), 32'd1);

    // Back-pressure: ready one cycle in three.
    do_reset();
    salt    = 16'hA000;
    enable  = 1'b1;
    rdy_pat = 1;
    load(32);
    wait_done(32, 300);
    rdy_pat = 0;
    chk("bp_pops", 32'(pop_cnt), 32'd32);
    chk("bp_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("bp_buf_max_le2", 32'(max_buf <= 2), 32'd1);

    // Underrun: empty forced for 5 cycles after 10 reads.
    do_reset();
    salt   = 16'h3C00;
    enable = 1'b1;
    load(32);
    for (int i = 0; i < 100 && rd_cnt < 10; i++) step();
    chk("ur_before", 32'(underrun), 32'd0);
    force_empty = 1'b1;
    repeat (5) step();
    force_empty = 1'b0;
    chk("ur_set", 32'(underrun), 32'd1);
    wait_done(32, 100);
    chk("ur_pops", 32'(pop_cnt), 32'd32);
    chk("ur_reads", 32'(rd_cnt), 32'd32);
    chk("ur_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("ur_sticky", 32'(underrun), 32'd1);

    // Reset after 7 samples.
    do_reset();
    salt   = 16'h7700;
    enable = 1'b1;
    load(32);
    for (int i = 0; i < 100 && pop_cnt < 7; i++) step();
    chk("mr_seven", 32'(pop_cnt), 32'd7);
    do_reset();
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_valid", 32'(m_valid), 32'd0);
    chk("mr_frame_cnt", 32'(frame_cnt), 32'd0);
    repeat (10) step();
    chk("mr_no_output", 32'(pop_cnt), 32'd0);
    chk("mr_no_read", 32'(rd_cnt), 32'd0);

    // Enable dropped after 7 samples: frame completes, no further frame.
    do_reset();
    salt   = 16'hE100;
    enable = 1'b1;
    load(64);
    for (int i = 0; i < 100 && pop_cnt < 7; i++) step();
    enable = 1'b0;
    wait_done(32, 100);
    repeat (40) step();
    chk("en_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("en_reads", 32'(rd_cnt), 32'd32);
    chk("en_pops", 32'(pop_cnt), 32'd32);
    chk("en_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lms_fifo_reader.md
# lms_fifo_reader

Read-side drain engine for the LMS audio path's asynchronous sample FIFO. It sits in the read clock domain and watches the FIFO's read water level. Once a full frame of FRAME_LEN samples is buffered, it pulls exactly that many samples using the FIFO's unregistered read port (1-cycle read latency). It presents them to the LMS filter as a valid/ready stream with a last-sample marker, absorbing downstream back-pressure in a 2-entry skid buffer.

## Interface
- DATA_WIDTH, 16, sample width; equals FIFO read data width.
- DEPTH_WIDTH, 10, FIFO read depth width; the water level is DEPTH_WIDTH+1 bits.
- FRAME_LEN, 32, samples per frame; legal 1..2^DEPTH_WIDTH.

- rd_clk  in  1  the only clock; the FIFO read clock.
- rd_rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  level; permits starting new frames.
- fifo_rd_en  out  1  FIFO read enable; data returns the following cycle.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data; valid the cycle after fifo_rd_en.
- fifo_rd_empty  in  1  FIFO empty flag.
- fifo_rd_water_level  in  DEPTH_WIDTH+1  FIFO read-side fill count.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  output sample.
- m_last  out  1  high with the FRAME_LEN-th sample of a frame.
- busy  out  1  high while state is not IDLE.
- frame_cnt  out  16  completed frames, wraps 0xFFFF→0.
- underrun  out  1  sticky; set on empty mid-frame; cleared only by reset.

## Operation
- States: IDLE, BURST, DRAIN.
- IDLE → BURST when enable=1, fifo_rd_water_level ≥ FRAME_LEN and fifo_rd_empty=0. On entry, issued_cnt and out_cnt clear to 0.
- BURST: fifo_rd_en = !fifo_rd_empty && issued_cnt < FRAME_LEN && (buf_cnt + inflight − pop) < 2.
  - inflight is the registered fifo_rd_en.
  - pop = m_valid && m_ready.
  - issued_cnt increments on each fifo_rd_en.
- BURST → DRAIN when issued_cnt reaches FRAME_LEN.
- DRAIN → IDLE on the handshake carrying m_last. On that cycle frame_cnt increments.
- Skid buffer: 2-entry FIFO.
  - Written in the cycle after fifo_rd_en, capturing fifo_rd_data.
  - m_valid = buf_cnt ≠ 0.
  - m_data = head entry.
  - m_last = (out_cnt == FRAME_LEN−1) && m_valid.
  - out_cnt increments on pop.
- Simultaneous push and pop: buf_cnt is unchanged. The buffer never overflows, and the issue rule guarantees it.
- Underrun: in BURST with issued_cnt < FRAME_LEN and fifo_rd_empty=1, set underrun. Stay in BURST and resume issuing when data arrives. The frame is never truncated.
- enable deasserted mid-frame: the current frame completes, and no new frame starts.
- m_ready=0: issuing stalls once buffer plus in-flight entries reach 2. m_data and m_last are held stable while m_valid=1 and m_ready=0.
- FRAME_LEN=1: the single sample carries m_last.
- Reset (rd_rst_n=0 at an edge): state→IDLE; counters, buffer and flags clear. Reset mid-frame discards in-flight data, and the returning read data is ignored.

## Timing
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, busy=0, frame_cnt=0, underrun=0.
- Threshold met in IDLE at cycle t:
  - BURST and fifo_rd_en=1 at t+1.
  - Data captured at the t+2 edge.
  - m_valid=1 at t+3.
- With m_ready=1 and no empty: one sample per cycle; m_valid on t+3..t+FRAME_LEN+2; m_last at t+FRAME_LEN+2.
- After the last handshake: IDLE the next cycle. The earliest next-frame fifo_rd_en is 2 cycles after the m_last handshake.
- fifo_rd_en is combinational from state, counters and fifo_rd_empty. All other outputs are registered or derived from registers.

## Test plan
- Reset and idle: hold rd_rst_n=0 for 3 cycles, water level 0 → all outputs 0; no fifo_rd_en ever.
- Single frame at full rate: FRAME_LEN=32, FIFO preloaded with 0..31, m_ready=1 → m_data 0..31 on 32 consecutive cycles. m_valid starts 3 cycles after threshold; m_last only on 31; frame_cnt=1; exactly 32 fifo_rd_en pulses.
- Back-pressure: m_ready toggled with a 1-of-3 pattern → sample order is intact, no loss or duplicate, and buf_cnt never exceeds 2. m_data is held while m_ready=0.
- Threshold gating: water level 31 with enable=1 → no read; raising the level to 32 starts the frame. enable=0 with level 64 → no read.
- Underrun: force fifo_rd_empty=1 for 5 cycles after 10 reads → underrun=1 and stays set; the frame resumes; all 32 samples are delivered with m_last on the 32nd.
- Mid-frame reset and enable drop:
  - Reset after 7 samples → IDLE, buffer empty, frame_cnt unchanged.
  - Separately, enable=0 after 7 samples → the frame completes; frame_cnt increments by 1; no further frames.
